// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 16-bit 5-stage CPU.
// Optional fetch/bubble performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [15:0] BranchAddr,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_2,
    output logic        flush_out,
    output logic [15:0] PC,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt,
`endif
    output logic        halted
);

    typedef enum logic {
        StRun    = 1'b0,
        StHalted = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        flush_q, flush_d;
    logic [15:0] pc_inc;
    logic        is_hlt;
    logic        load_real;
    logic        load_bubble;

    assign pc_inc = pc_q + 16'd2;
    assign is_hlt = (imem_data[15:12] == HLT_OPCODE);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc2_d       = pc2_q;
        flush_d     = flush_q;
        load_real   = 1'b0;
        load_bubble = 1'b0;
        if (stall_in) begin
            // Full hold; a flush seen during a stall is re-issued by DECODE later.
        end else if (flush_in) begin
            pc_d        = BranchAddr;
            instr_d     = NOP_INSTR;
            pc2_d       = 16'h0000;
            flush_d     = 1'b1;
            state_d     = StRun;
            load_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StHalted: begin
                    instr_d     = NOP_INSTR;
                    pc2_d       = 16'h0000;
                    flush_d     = 1'b1;
                    load_bubble = 1'b1;
                end
                default: begin
                    instr_d   = imem_data;
                    pc2_d     = pc_inc;
                    flush_d   = 1'b0;
                    load_real = 1'b1;
                    if (is_hlt) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            flush_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            flush_q <= flush_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_real && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign instruction = instr_q;
    assign PC_plus_2   = pc2_q;
    assign flush_out   = flush_q;
    assign halted      = (state_q == StHalted);

endmodule
